// File: rtl/axis_pattern_gen_if.sv
// AXI4-Stream video bundle between the pattern generator and the LCD stage.
interface axis_pattern_gen_if;
    logic [31:0] axis_tdata;
    logic        axis_tvalid;
    logic        axis_tready;
    logic        axis_tuser;
    logic        axis_tlast;
    logic [3:0]  axis_tstrb;

    modport master (
        output axis_tdata, axis_tvalid, axis_tuser, axis_tlast, axis_tstrb,
        input  axis_tready
    );

    modport slave (
        input  axis_tdata, axis_tvalid, axis_tuser, axis_tlast, axis_tstrb,
        output axis_tready
    );
endinterface

// File: rtl/axis_pattern_gen.sv
// AXI4-Stream test-pattern source: colour bars, ramp, checkerboard, solid colour.
// Define AXIS_PATGEN_CHECKER_EN to build the checkerboard; otherwise pattern 2 is solid.
module axis_pattern_gen #(
    parameter int          H_ACT     = 480,
    parameter int          V_ACT     = 272,
    parameter logic [23:0] SOLID_RGB = 24'hFF0000
) (
    input  logic                       axis_aclk,
    input  logic                       axis_aresetn,
    input  logic                       enable,
    input  logic [1:0]                 pattern_sel,
    output logic                       frame_done,
    axis_pattern_gen_if.master         m_axis
);

    localparam logic [11:0] X_LAST  = 12'(H_ACT - 1);
    localparam logic [11:0] Y_LAST  = 12'(V_ACT - 1);
    localparam logic [11:0] BX_LAST = 12'(H_ACT / 8 - 1);

    typedef enum logic {S_IDLE = 1'b0, S_ACTIVE = 1'b1} state_t;

    state_t      r_state, w_state_nxt;
    logic [11:0] r_x, r_y, r_bx;
    logic [2:0]  r_bar;
    logic [23:0] r_idx;
    logic [1:0]  r_pat;
    logic [31:0] r_tdata;
    logic        r_tvalid, r_tuser, r_tlast, r_frame_done;
    logic [3:0]  r_tstrb;

    logic        w_xfer, w_last_px, w_start, w_adv, w_stop;
    logic [11:0] w_nx, w_ny, w_nbx;
    logic [2:0]  w_nbar;
    logic [23:0] w_nidx, w_rgb;
    logic [1:0]  w_npat;

    function automatic logic [23:0] f_bar_rgb(input logic [2:0] bar);
        case (bar)
            3'd0:    return 24'hFFFFFF;
            3'd1:    return 24'hFFFF00;
            3'd2:    return 24'h00FFFF;
            3'd3:    return 24'h00FF00;
            3'd4:    return 24'hFF00FF;
            3'd5:    return 24'hFF0000;
            3'd6:    return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    assign w_xfer    = r_tvalid & m_axis.axis_tready;
    assign w_last_px = (r_x == X_LAST) && (r_y == Y_LAST);

    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) r_state <= S_IDLE;
        else               r_state <= w_state_nxt;
    end

    // enable only matters in IDLE and on the final pixel of a frame
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (enable) w_state_nxt = S_ACTIVE;
            S_ACTIVE: if (w_xfer && w_last_px && !enable) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_start = 1'b0;
        w_adv   = 1'b0;
        w_stop  = 1'b0;
        case (r_state)
            S_IDLE: w_start = enable;
            S_ACTIVE: begin
                if (w_xfer) begin
                    if (w_last_px) begin
                        w_start = enable;
                        w_stop  = !enable;
                    end else begin
                        w_adv = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    // coordinates and counters of the pixel to be presented next
    always_comb begin
        w_nx   = r_x;
        w_ny   = r_y;
        w_nbx  = r_bx;
        w_nbar = r_bar;
        w_nidx = r_idx;
        w_npat = r_pat;
        if (w_start) begin
            w_nx   = '0;
            w_ny   = '0;
            w_nbx  = '0;
            w_nbar = '0;
            w_nidx = '0;
            w_npat = pattern_sel;
        end else if (w_adv) begin
            w_nidx = r_idx + 24'd1;
            if (r_x == X_LAST) begin
                w_nx   = '0;
                w_ny   = r_y + 12'd1;
                w_nbx  = '0;
                w_nbar = '0;
            end else begin
                w_nx = r_x + 12'd1;
                if (r_bx == BX_LAST) begin
                    w_nbx  = '0;
                    w_nbar = r_bar + 3'd1;
                end else begin
                    w_nbx = r_bx + 12'd1;
                end
            end
        end
    end

    always_comb begin
        w_rgb = SOLID_RGB;
        case (w_npat)
            2'd0: w_rgb = f_bar_rgb(w_nbar);
            2'd1: w_rgb = w_nidx;
`ifdef AXIS_PATGEN_CHECKER_EN
            2'd2: w_rgb = (w_nx[5] ^ w_ny[5]) ? 24'h000000 : 24'hFFFFFF;
`endif
            default: w_rgb = SOLID_RGB;
        endcase
    end

    // output register stage: beat is loaded only on start or after a transfer
    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            r_x          <= '0;
            r_y          <= '0;
            r_bx         <= '0;
            r_bar        <= '0;
            r_idx        <= '0;
            r_pat        <= '0;
            r_tdata      <= '0;
            r_tvalid     <= 1'b0;
            r_tuser      <= 1'b0;
            r_tlast      <= 1'b0;
            r_tstrb      <= 4'h0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_xfer & w_last_px;
            if (w_start || w_adv) begin
                r_x      <= w_nx;
                r_y      <= w_ny;
                r_bx     <= w_nbx;
                r_bar    <= w_nbar;
                r_idx    <= w_nidx;
                r_pat    <= w_npat;
                r_tdata  <= {8'h00, w_rgb};
                r_tvalid <= 1'b1;
                r_tuser  <= w_start;
                r_tlast  <= (w_nx == X_LAST);
                r_tstrb  <= 4'hF;
            end else if (w_stop) begin
                r_x      <= '0;
                r_y      <= '0;
                r_bx     <= '0;
                r_bar    <= '0;
                r_idx    <= '0;
                r_tdata  <= '0;
                r_tvalid <= 1'b0;
                r_tuser  <= 1'b0;
                r_tlast  <= 1'b0;
                r_tstrb  <= 4'h0;
            end
        end
    end

    assign m_axis.axis_tdata  = r_tdata;
    assign m_axis.axis_tvalid = r_tvalid;
    assign m_axis.axis_tuser  = r_tuser;
    assign m_axis.axis_tlast  = r_tlast;
    assign m_axis.axis_tstrb  = r_tstrb;
    assign frame_done         = r_frame_done;

endmodule

// File: tb/tb_axis_pattern_gen.sv
// Randomised and directed bench for axis_pattern_gen: a 16x2 and a 64x40 instance
// checked every cycle against a pixel-index reference model.
module tb_axis_pattern_gen;

    localparam int H0 = 16, V0 = 2, H1 = 64, V1 = 40;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n;
    logic [1:0]      en, rdy, fd;
    logic [1:0][1:0] sel;
    logic [1:0][31:0] o_data;
    logic [1:0][3:0]  o_strb;
    logic [1:0]       o_vld, o_usr, o_lst;

    axis_pattern_gen_if if0 ();
    axis_pattern_gen_if if1 ();

    assign if0.axis_tready = rdy[0];
    assign if1.axis_tready = rdy[1];
    assign o_data[0] = if0.axis_tdata;  assign o_data[1] = if1.axis_tdata;
    assign o_vld[0]  = if0.axis_tvalid; assign o_vld[1]  = if1.axis_tvalid;
    assign o_usr[0]  = if0.axis_tuser;  assign o_usr[1]  = if1.axis_tuser;
    assign o_lst[0]  = if0.axis_tlast;  assign o_lst[1]  = if1.axis_tlast;
    assign o_strb[0] = if0.axis_tstrb;  assign o_strb[1] = if1.axis_tstrb;

    axis_pattern_gen #(.H_ACT(H0), .V_ACT(V0), .SOLID_RGB(24'hFF0000)) dut0 (
        .axis_aclk(clk), .axis_aresetn(rst_n), .enable(en[0]),
        .pattern_sel(sel[0]), .frame_done(fd[0]), .m_axis(if0.master));

    axis_pattern_gen #(.H_ACT(H1), .V_ACT(V1), .SOLID_RGB(24'hFF0000)) dut1 (
        .axis_aclk(clk), .axis_aresetn(rst_n), .enable(en[1]),
        .pattern_sel(sel[1]), .frame_done(fd[1]), .m_axis(if1.master));

    int checks = 0;
    int errors = 0;
    int fd_at0 = -1;
    int HS[2] = '{H0, H1};
    int NS[2] = '{H0 * V0, H1 * V1};
    logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                              24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    logic [33:0] lg0 [$];
    logic [33:0] lg1 [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // colour of pixel number k of a frame h pixels wide
    function automatic logic [23:0] exp_rgb(input int h, input logic [1:0] pat, input int k);
        int x, y;
        logic [31:0] kv;
        x  = k % h;
        y  = k / h;
        kv = k;
        case (pat)
            2'd0: return bars[x / (h / 8)];
            2'd1: return kv[23:0];
`ifdef AXIS_PATGEN_CHECKER_EN
            2'd2: return (((x / 32) + (y / 32)) % 2 == 0) ? 24'hFFFFFF : 24'h000000;
`endif
            default: return 24'hFF0000;
        endcase
    endfunction

    // reference model: frame active flag, index of presented pixel, latched pattern
    bit         m_act   [2];
    int         m_k     [2];
    logic [1:0] m_pat   [2];
    bit         m_done  [2];
    bit         m_stall [2];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                m_act[i]   <= 1'b0;
                m_k[i]     <= 0;
                m_pat[i]   <= 2'd0;
                m_done[i]  <= 1'b0;
                m_stall[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                m_done[i]  <= m_act[i] && rdy[i] && (m_k[i] == NS[i] - 1);
                m_stall[i] <= m_act[i] && !rdy[i];
                if (!m_act[i]) begin
                    if (en[i]) begin
                        m_act[i] <= 1'b1;
                        m_k[i]   <= 0;
                        m_pat[i] <= sel[i];
                    end
                end else if (rdy[i]) begin
                    if (m_k[i] == NS[i] - 1) begin
                        m_k[i] <= 0;
                        if (en[i]) m_pat[i] <= sel[i];
                        else       m_act[i] <= 1'b0;
                    end else begin
                        m_k[i] <= m_k[i] + 1;
                    end
                end
            end
        end
    end

    logic [1:0][31:0] p_data;
    logic [1:0]       p_usr, p_lst;

    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (m_act[i]) begin
                    chk($sformatf("d%0d tvalid k=%0d", i, m_k[i]), o_vld[i], 1);
                    chk($sformatf("d%0d tdata k=%0d", i, m_k[i]), o_data[i],
                        {8'h00, exp_rgb(HS[i], m_pat[i], m_k[i])});
                    chk($sformatf("d%0d tuser k=%0d", i, m_k[i]), o_usr[i], m_k[i] == 0);
                    chk($sformatf("d%0d tlast k=%0d", i, m_k[i]), o_lst[i],
                        (m_k[i] % HS[i]) == HS[i] - 1);
                    chk($sformatf("d%0d tstrb", i), o_strb[i], 4'hF);
                end else begin
                    chk($sformatf("d%0d idle tvalid", i), o_vld[i], 0);
                    chk($sformatf("d%0d idle tstrb", i), o_strb[i], 0);
                    chk($sformatf("d%0d idle tuser", i), o_usr[i], 0);
                    chk($sformatf("d%0d idle tlast", i), o_lst[i], 0);
                end
                if (!rst_n) chk($sformatf("d%0d reset tdata", i), o_data[i], 0);
                chk($sformatf("d%0d frame_done", i), fd[i], m_done[i]);
                if (m_stall[i]) begin
                    chk($sformatf("d%0d stall tdata", i), o_data[i], p_data[i]);
                    chk($sformatf("d%0d stall tuser", i), o_usr[i], p_usr[i]);
                    chk($sformatf("d%0d stall tlast", i), o_lst[i], p_lst[i]);
                end
                p_data[i] = o_data[i];
                p_usr[i]  = o_usr[i];
                p_lst[i]  = o_lst[i];
            end
            if (fd[0] && fd_at0 < 0) fd_at0 = lg0.size();
            if (o_vld[0] && rdy[0]) lg0.push_back({o_usr[0], o_lst[0], o_data[0]});
            if (o_vld[1] && rdy[1]) lg1.push_back({o_usr[1], o_lst[1], o_data[1]});
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_log(input int id, input int n, input int budget);
        int c;
        c = 0;
        while (((id == 0) ? lg0.size() : lg1.size()) < n && c < budget) begin
            cyc(1);
            c++;
        end
        chk($sformatf("d%0d transfers reached %0d", id, n),
            ((id == 0) ? lg0.size() : lg1.size()) >= n, 1);
    endtask

    task automatic wait_idle(input int budget);
        int c;
        c = 0;
        while (o_vld != 2'b00 && c < budget) begin
            cyc(1);
            c++;
        end
        chk("both idle", o_vld, 0);
    endtask

    initial begin
        int ucount;
        rst_n = 1'b0; en = '0; rdy = '0; sel = '0;
        cyc(3);
        chk("reset tvalid", o_vld, 0);
        chk("reset tdata0", o_data[0], 0);
        chk("reset frame_done", fd, 0);
        rst_n = 1'b1;
        cyc(2);

        // single-cycle enable: exactly one 16x2 colour-bar frame
        lg0.delete(); fd_at0 = -1;
        sel[0] = 2'd0; rdy[0] = 1'b1; en[0] = 1'b1;
        cyc(1);
        en[0] = 1'b0;
        wait_log(0, 32, 100);
        cyc(4);
        chk("bars count", lg0.size(), 32);
        chk("bars px0", lg0[0][31:0], 32'h00FFFFFF);
        chk("bars px1", lg0[1][31:0], 32'h00FFFFFF);
        chk("bars px14", lg0[14][31:0], 32'h00000000);
        chk("bars px15", lg0[15][31:0], 32'h00000000);
        chk("bars tuser0", lg0[0][33], 1);
        chk("bars tlast15", lg0[15][32], 1);
        chk("bars tlast31", lg0[31][32], 1);
        chk("bars tlast14", lg0[14][32], 0);
        ucount = 0;
        foreach (lg0[j]) ucount += int'(lg0[j][33]);
        chk("bars tuser count", ucount, 1);
        chk("frame_done after transfer", fd_at0, 32);
        chk("idle after frame", o_vld[0], 0);

        // ramp under alternating ready
        lg0.delete();
        sel[0] = 2'd1; en[0] = 1'b1; rdy[0] = 1'b0;
        cyc(1);
        en[0] = 1'b0;
        for (int c = 0; c < 200 && lg0.size() < 32; c++) begin
            rdy[0] = ~rdy[0];
            cyc(1);
        end
        rdy[0] = 1'b1;
        cyc(4);
        chk("ramp count", lg0.size(), 32);
        for (int j = 0; j < 32; j++) chk($sformatf("ramp[%0d]", j), lg0[j][31:0], 32'(j));

        // pattern change mid-frame takes effect on the next frame
        lg0.delete();
        sel[0] = 2'd0; rdy[0] = 1'b1; en[0] = 1'b1;
        wait_log(0, 5, 50);
        sel[0] = 2'd3;
        wait_log(0, 40, 100);
        en[0] = 1'b0;
        wait_log(0, 64, 100);
        cyc(4);
        chk("sel change count", lg0.size(), 64);
        chk("frame1 px5", lg0[5][31:0], 32'h0000FFFF);
        chk("frame1 px31", lg0[31][31:0], 32'h00000000);
        chk("frame2 px0", lg0[32][31:0], 32'h00FF0000);
        chk("frame2 tuser", lg0[32][33], 1);
        chk("frame2 px63", lg0[63][31:0], 32'h00FF0000);

        // pattern 2 on the 64-wide instance
        lg1.delete();
        sel[1] = 2'd2; rdy[1] = 1'b1; en[1] = 1'b1;
        cyc(1);
        en[1] = 1'b0;
        wait_log(1, H1 * V1, 3000);
        cyc(4);
`ifdef AXIS_PATGEN_CHECKER_EN
        chk("checker (32,0)", lg1[32][31:0], 32'h00000000);
        chk("checker (32,32)", lg1[32 * H1 + 32][31:0], 32'h00FFFFFF);
`else
        chk("checker off (32,0)", lg1[32][31:0], 32'h00FF0000);
        chk("checker off (32,32)", lg1[32 * H1 + 32][31:0], 32'h00FF0000);
`endif

        // random ready/enable/pattern on both instances
        for (int n = 0; n < 3000; n++) begin
            en  = {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)};
            rdy = {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)};
            sel = {2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
            cyc(1);
        end
        en = '0; rdy = 2'b11;
        wait_idle(6000);

        // reset while stalled mid-frame
        lg0.delete();
        sel[0] = 2'd0; rdy[0] = 1'b1; en[0] = 1'b1;
        wait_log(0, 10, 50);
        rdy[0] = 1'b0;
        cyc(2);
        rst_n = 1'b0;
        #1;
        chk("async reset tvalid", o_vld[0], 0);
        chk("async reset tdata", o_data[0], 0);
        chk("async reset tstrb", o_strb[0], 0);
        cyc(2);
        rst_n = 1'b1;
        lg0.delete();
        rdy[0] = 1'b1;
        wait_log(0, 1, 20);
        chk("restart tuser", lg0[0][33], 1);
        chk("restart px0", lg0[0][31:0], 32'h00FFFFFF);
        en[0] = 1'b0;
        wait_idle(200);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

endmodule
